mem_lsu_stage: RTL and testbench
================================

# mem_lsu_stage

Pipeline memory-access stage that sits directly downstream of the execute stage and upstream of write-back. It accepts one instruction per valid/allowin handshake and issues at most one request per instruction on the data SRAM-like bus (req/addr_ok/data_ok). It aligns and extends load data, forms store byte strobes, and detects address-misalignment (ALE). It then hands the result to write-back and exposes a forwarding port to decode. Flushes arriving while a request is in flight are absorbed by cancel states, so no stale `data_ok` ever reaches a later instruction.

## Interface
- No parameters.
- `clk  in  1  clock`
- `rst  in  1  asynchronous, active-high reset`
- `es_to_ms_valid  in  1  execute stage presents an instruction`
- `ms_allowin  out  1  this stage can accept this cycle`
- `es_mem_op  in  10  one-hot: [0]ld_b [1]ld_bu [2]ld_h [3]ld_hu [4]ld_w [5]st_b [6]st_h [7]st_w; [9:8] reserved, must be 0`
- `es_addr  in  32  ALU result: effective address, or result for non-memory ops`
- `es_wdata  in  32  store source (rkd value)`
- `es_gr_we / es_dest / es_pc  in  1/5/32  write-back controls`
- `es_excp  in  1  instruction already carries an exception; suppress the memory request`
- `flush  in  1  pipeline flush (exception/ertn commit)`
- `data_sram_req / data_sram_wr  out  1/1  request, 1 = write`
- `data_sram_size  out  2  0 = byte, 1 = half, 2 = word`
- `data_sram_wstrb  out  4  byte enables (0 for loads)`
- `data_sram_addr / data_sram_wdata  out  32/32`
- `data_sram_addr_ok / data_sram_data_ok  in  1/1  address accepted / data returned`
- `data_sram_rdata  in  32`
- `ms_to_ws_valid  out  1`; `ws_allowin  in  1`
- `ws_result / ws_pc  out  32/32`; `ws_dest  out  5`; `ws_gr_we  out  1`
- `ms_excp  out  1  es_excp OR ALE`; `ms_ale  out  1  misaligned access detected here`
- `ms_fwd_valid  out  1  valid && gr_we`; `ms_fwd_ready  out  1  ws_result final`; `ms_fwd_dest / ms_fwd_data  out  5/32`

## Operation
- **Capture.** Input fields are registered when `es_to_ms_valid && ms_allowin`.
- **ALE check** on the captured address:
  - half ops with `addr[0] != 0`;
  - word ops with `addr[1:0] != 0`;
  - byte ops never fault.
  - On ALE: `ms_ale = 1`, `ws_result = addr` (the bad virtual address), no request is issued.
- **Next state after capture:**
  - REQ if the op is a memory op and there is no `es_excp` and no ALE;
  - otherwise DONE, with `ws_result = es_addr`.
- **States:** IDLE, REQ, WAIT, DONE, CXL_REQ, CXL_WAIT.
  - REQ: `data_sram_req = 1`. On `addr_ok` → WAIT.
  - WAIT: on `data_ok` → DONE; load data is captured.
  - DONE: on `ws_allowin` → IDLE, or back to capture if a new instruction is accepted in the same cycle.
  - CXL_REQ: keeps `req` asserted with the same fields. On `addr_ok` → CXL_WAIT.
  - CXL_WAIT: on `data_ok` → IDLE; data is discarded.
- **Flush:**
  - Flush in IDLE or DONE → IDLE.
  - Flush in REQ → CXL_REQ, or CXL_WAIT if `addr_ok` arrives in the same cycle.
  - Flush in WAIT → CXL_WAIT, or IDLE if `data_ok` arrives in the same cycle.
  - Flush clears `valid` immediately in every case.
- **Store encoding**, with `off = addr[1:0]`:
  - `st_b`: `wstrb = 4'b0001 << off`, `wdata = {4{wdata[7:0]}}`.
  - `st_h`: `wstrb = 4'b0011 << off`, `wdata = {2{wdata[15:0]}}`.
  - `st_w`: `wstrb = 4'hF`.
  - Store `data_ok` completes the op; `ws_result` = `es_addr`.
- **Load extraction:** `sh = rdata >> (8*off)`.
  - `ld_b`/`ld_bu` take `sh[7:0]`, sign- or zero-extended.
  - `ld_h`/`ld_hu` take `sh[15:0]`, sign- or zero-extended.
  - `ld_w` takes `rdata` unchanged.
- **Request fields:** `addr`, `size` and `wr` are driven from the registered fields while in REQ or CXL_REQ. They are 0 otherwise.
- **Reserved ops:** `es_mem_op[9:8]` set is treated as a non-memory op.

## Timing
- **Reset:** state IDLE, `valid = 0`. Every output is 0 except `ms_allowin = 1`.
- **Handshake signals:**
  - `ready_go = (state == DONE)`.
  - `ms_allowin = !cancel_state && (!valid || (ready_go && ws_allowin))`.
  - `ms_to_ws_valid = valid && ready_go && !flush`.
- **Latency, capture to DONE:**
  - Non-memory or faulting op: 1 cycle.
  - Memory op: ≥3 cycles (REQ→WAIT needs `addr_ok`; `data_ok` comes no earlier than the cycle after `addr_ok`).
- **Back-to-back throughput:** one instruction per 3 cycles when the bus has zero wait states.
- **Request persistence:** `data_sram_req` never drops before `addr_ok`, including under flush. At most one transaction is outstanding.
- **Forwarding:** `ms_fwd_ready` asserts only in DONE. Decode must stall on `ms_fwd_valid && !ms_fwd_ready`.
- **Reset mid-transaction:** returns to IDLE immediately. The bus slave is reset with the same signal.

## Test plan
- **Load, signed byte:** `ld_b`, addr `0x1C000003`, `rdata = 0x80FF1234`; `addr_ok` one cycle after req, `data_ok` one cycle later → `ws_result = 0xFFFFFF80`, `ms_to_ws_valid` 3 cycles after capture, `size = 0`, `wstrb = 0`.
- **Store, half:** `st_h`, addr `...2`, `wdata = 0x0000BEEF` → `wr = 1`, `wstrb = 4'b1100`, `data_sram_wdata = 0xBEEFBEEF`, `size = 1`.
- **ALE:** `ld_w` at `0x1C000006` → no `req` ever, `ms_ale = 1`, `ms_excp = 1`, `ws_result = 0x1C000006`, valid out 1 cycle after capture.
- **Flush while waiting:** flush asserted in WAIT; `data_ok = 0xDEADBEEF` arrives 2 cycles later → `ms_allowin = 0` until that `data_ok`, no `ms_to_ws_valid`, next load returns its own data.
- **Flush in REQ with `addr_ok` stalled 3 cycles** → `req` held with unchanged addr until `addr_ok`, then CXL_WAIT, then IDLE after `data_ok`.
- **Back-pressure:** `ws_allowin = 0` for 4 cycles in DONE → outputs stable, `ms_allowin = 0`, `ms_fwd_ready = 1`; release → handover and new capture in the same cycle.

Source files
------------

// File: rtl/mem_lsu_stage.sv
// -----------------------------------------------------------------------------
// mem_lsu_stage
//
// Memory-access pipeline stage between execute and write-back. Accepts one
// instruction per es_to_ms_valid_i / ms_allowin_o handshake. Memory ops issue
// at most one request on an SRAM-like data bus (req / addr_ok / data_ok).
// Load data is aligned and extended here, store strobes and lane data are
// formed here, and address misalignment (ALE) is detected here. A flush that
// lands while a bus transaction is in flight is absorbed by two cancel states,
// so the late data_ok of a squashed access is never taken by a newer one.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   es_to_ms_valid_i / ms_allowin_o    upstream handshake
//   es_mem_op_i[9:0]               one-hot op: [0]ld_b [1]ld_bu [2]ld_h
//                                  [3]ld_hu [4]ld_w [5]st_b [6]st_h [7]st_w;
//                                  [9:8] reserved (set -> non-memory op)
//   es_addr_i, es_wdata_i          effective address / ALU result, store data
//   es_gr_we_i, es_dest_i, es_pc_i write-back controls
//   es_excp_i                      instruction already faulted, no request
//   flush_i                        pipeline flush
//   data_sram_*                    data bus master side
//   ms_to_ws_valid_o / ws_allowin_i    downstream handshake
//   ws_result_o, ws_pc_o, ws_dest_o, ws_gr_we_o   write-back payload
//   ms_excp_o, ms_ale_o            exception flags (valid-qualified)
//   ms_fwd_*                       forwarding port towards decode
// -----------------------------------------------------------------------------
module mem_lsu_stage (
  input  logic        clk,
  input  logic        rst,
  // upstream
  input  logic        es_to_ms_valid_i,
  output logic        ms_allowin_o,
  input  logic [9:0]  es_mem_op_i,
  input  logic [31:0] es_addr_i,
  input  logic [31:0] es_wdata_i,
  input  logic        es_gr_we_i,
  input  logic [4:0]  es_dest_i,
  input  logic [31:0] es_pc_i,
  input  logic        es_excp_i,
  input  logic        flush_i,
  // data bus
  output logic        data_sram_req_o,
  output logic        data_sram_wr_o,
  output logic [1:0]  data_sram_size_o,
  output logic [3:0]  data_sram_wstrb_o,
  output logic [31:0] data_sram_addr_o,
  output logic [31:0] data_sram_wdata_o,
  input  logic        data_sram_addr_ok_i,
  input  logic        data_sram_data_ok_i,
  input  logic [31:0] data_sram_rdata_i,
  // downstream
  output logic        ms_to_ws_valid_o,
  input  logic        ws_allowin_i,
  output logic [31:0] ws_result_o,
  output logic [31:0] ws_pc_o,
  output logic [4:0]  ws_dest_o,
  output logic        ws_gr_we_o,
  output logic        ms_excp_o,
  output logic        ms_ale_o,
  // forwarding
  output logic        ms_fwd_valid_o,
  output logic        ms_fwd_ready_o,
  output logic [4:0]  ms_fwd_dest_o,
  output logic [31:0] ms_fwd_data_o
);

  // One-hot op bit positions
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;
  localparam int ST_B  = 5;
  localparam int ST_H  = 6;
  localparam int ST_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_DONE     = 3'd3,
    S_CXL_REQ  = 3'd4,
    S_CXL_WAIT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;

  // Captured instruction fields
  logic [7:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        gr_we_q;
  logic [4:0]  dest_q;
  logic [31:0] pc_q;
  logic        excp_q;
  logic        ale_q;

  // ---------------------------------------------------------------------------
  // Incoming-op decode (evaluated on the execute-stage fields at capture)
  // ---------------------------------------------------------------------------
  logic       in_reserved;
  logic [7:0] in_op;
  logic       in_mem;
  logic       in_half;
  logic       in_word;
  logic       in_ale;
  logic       in_go_req;
  state_t     cap_state;

  // Any reserved bit demotes the whole op to a plain ALU pass-through, so the
  // stored op vector is cleared and nothing downstream sees a memory op.
  assign in_reserved = |es_mem_op_i[9:8];
  assign in_op       = in_reserved ? 8'h00 : es_mem_op_i[7:0];
  assign in_mem      = |in_op;
  assign in_half     = in_op[LD_H] | in_op[LD_HU] | in_op[ST_H];
  assign in_word     = in_op[LD_W] | in_op[ST_W];
  assign in_ale      = (in_half && es_addr_i[0]) ||
                       (in_word && (es_addr_i[1:0] != 2'b00));
  assign in_go_req   = in_mem && !es_excp_i && !in_ale;
  assign cap_state   = in_go_req ? S_REQ : S_DONE;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic cancel_state;
  logic ready_go;
  logic accept;

  assign cancel_state     = (state_q == S_CXL_REQ) || (state_q == S_CXL_WAIT);
  assign ready_go         = (state_q == S_DONE);
  assign ms_allowin_o     = !cancel_state && (!valid_q || (ready_go && ws_allowin_i));
  assign ms_to_ws_valid_o = valid_q && ready_go && !flush_i;
  // An instruction offered in the same cycle as a flush belongs to the
  // squashed path and is never captured.
  assign accept           = es_to_ms_valid_i && ms_allowin_o && !flush_i;

  // ---------------------------------------------------------------------------
  // Captured-op decode
  // ---------------------------------------------------------------------------
  logic       is_load_q;
  logic       is_store_q;
  logic [1:0] off_q;

  assign is_load_q  = |op_q[LD_W:LD_B];
  assign is_store_q = |op_q[ST_W:ST_B];
  assign off_q      = addr_q[1:0];

  // ---------------------------------------------------------------------------
  // Load extraction: shift the addressed byte/half down to bit 0, then extend
  // ---------------------------------------------------------------------------
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign ld_shift = data_sram_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_data = data_sram_rdata_i;
    if (op_q[LD_B]) begin
      ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
    end else if (op_q[LD_BU]) begin
      ld_data = {24'h000000, ld_shift[7:0]};
    end else if (op_q[LD_H]) begin
      ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
    end else if (op_q[LD_HU]) begin
      ld_data = {16'h0000, ld_shift[15:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Store lane data: replicate the byte / half so every lane carries it and
  // the strobes alone select the target bytes.
  // ---------------------------------------------------------------------------
  logic [7:0]  st_lane [4];
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_st_lane
      assign st_lane[gi] = op_q[ST_B] ? wdata_q[7:0] :
                           op_q[ST_H] ? wdata_q[8*(gi%2) +: 8] :
                                        wdata_q[8*gi +: 8];
    end
  endgenerate

  assign st_wdata = {st_lane[3], st_lane[2], st_lane[1], st_lane[0]};

  always_comb begin
    st_wstrb = 4'b0000;
    if (op_q[ST_B]) begin
      st_wstrb = 4'b0001 << off_q;
    end else if (op_q[ST_H]) begin
      st_wstrb = 4'b0011 << off_q;
    end else if (op_q[ST_W]) begin
      st_wstrb = 4'b1111;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus request outputs. CXL_REQ keeps presenting the same request: the slave
  // may already be committed to it, so req cannot be withdrawn before addr_ok.
  // ---------------------------------------------------------------------------
  logic       req_state;
  logic [1:0] size_q;

  assign req_state = (state_q == S_REQ) || (state_q == S_CXL_REQ);

  always_comb begin
    size_q = 2'd0;
    if (op_q[LD_H] || op_q[LD_HU] || op_q[ST_H]) begin
      size_q = 2'd1;
    end else if (op_q[LD_W] || op_q[ST_W]) begin
      size_q = 2'd2;
    end
  end

  assign data_sram_req_o   = req_state;
  assign data_sram_wr_o    = req_state && is_store_q;
  assign data_sram_size_o  = req_state ? size_q : 2'd0;
  assign data_sram_addr_o  = req_state ? addr_q : 32'h0;
  assign data_sram_wstrb_o = (req_state && is_store_q) ? st_wstrb : 4'b0000;
  assign data_sram_wdata_o = (req_state && is_store_q) ? st_wdata : 32'h0;

  // ---------------------------------------------------------------------------
  // Next-state / valid / result
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = cap_state;
      end
      S_REQ: begin
        if (flush_i) begin
          state_d = data_sram_addr_ok_i ? S_CXL_WAIT : S_CXL_REQ;
        end else if (data_sram_addr_ok_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush coinciding with data_ok retires the access outright.
        if (flush_i) begin
          state_d = data_sram_data_ok_i ? S_IDLE : S_CXL_WAIT;
        end else if (data_sram_data_ok_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (ws_allowin_i) begin
          state_d = accept ? cap_state : S_IDLE;
        end
      end
      S_CXL_REQ: begin
        if (data_sram_addr_ok_i) state_d = S_CXL_WAIT;
      end
      S_CXL_WAIT: begin
        if (data_sram_data_ok_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (ready_go && ws_allowin_i) begin
      valid_d = 1'b0;
    end

    // Result defaults to the address (ALU result, store address or bad
    // virtual address on ALE) and is replaced by load data on return.
    if (accept) begin
      result_d = es_addr_i;
    end else if ((state_q == S_WAIT) && data_sram_data_ok_i && !flush_i && is_load_q) begin
      result_d = ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 8'h00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      gr_we_q <= 1'b0;
      dest_q  <= 5'd0;
      pc_q    <= 32'h0;
      excp_q  <= 1'b0;
      ale_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= in_op;
      addr_q  <= es_addr_i;
      wdata_q <= es_wdata_i;
      gr_we_q <= es_gr_we_i;
      dest_q  <= es_dest_i;
      pc_q    <= es_pc_i;
      excp_q  <= es_excp_i;
      ale_q   <= in_ale;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back and forwarding outputs
  // ---------------------------------------------------------------------------
  assign ws_result_o    = result_q;
  assign ws_pc_o        = pc_q;
  assign ws_dest_o      = dest_q;
  assign ws_gr_we_o     = gr_we_q;
  assign ms_excp_o      = valid_q && (excp_q || ale_q);
  assign ms_ale_o       = valid_q && ale_q;

  // The forwarded value is only final once the access has completed.
  assign ms_fwd_valid_o = valid_q && gr_we_q;
  assign ms_fwd_ready_o = valid_q && ready_go;
  assign ms_fwd_dest_o  = dest_q;
  assign ms_fwd_data_o  = result_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
module tb_mem_lsu_stage;

  localparam logic [9:0] OP_NONE = 10'h000;
  localparam logic [9:0] OP_LD_B  = 10'h001;
  localparam logic [9:0] OP_LD_BU = 10'h002;
  localparam logic [9:0] OP_LD_H  = 10'h004;
  localparam logic [9:0] OP_LD_HU = 10'h008;
  localparam logic [9:0] OP_LD_W  = 10'h010;
  localparam logic [9:0] OP_ST_B  = 10'h020;
  localparam logic [9:0] OP_ST_H  = 10'h040;
  localparam logic [9:0] OP_ST_W  = 10'h080;
  localparam logic [9:0] OP_RSVD  = 10'h201;

  logic        clk = 1'b0;
  logic        rst;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [9:0]  es_mem_op;
  logic [31:0] es_addr, es_wdata, es_pc;
  logic        es_gr_we, es_excp, flush;
  logic [4:0]  es_dest;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] baddr, bwdata, rdata;
  logic        addr_ok, data_ok;
  logic        ms_to_ws_valid, ws_allowin;
  logic [31:0] ws_result, ws_pc;
  logic [4:0]  ws_dest;
  logic        ws_gr_we, ms_excp, ms_ale;
  logic        fwd_valid, fwd_ready;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  mem_lsu_stage dut (
    .clk               (clk),
    .rst               (rst),
    .es_to_ms_valid_i  (es_to_ms_valid),
    .ms_allowin_o      (ms_allowin),
    .es_mem_op_i       (es_mem_op),
    .es_addr_i         (es_addr),
    .es_wdata_i        (es_wdata),
    .es_gr_we_i        (es_gr_we),
    .es_dest_i         (es_dest),
    .es_pc_i           (es_pc),
    .es_excp_i         (es_excp),
    .flush_i           (flush),
    .data_sram_req_o   (req),
    .data_sram_wr_o    (wr),
    .data_sram_size_o  (size),
    .data_sram_wstrb_o (wstrb),
    .data_sram_addr_o  (baddr),
    .data_sram_wdata_o (bwdata),
    .data_sram_addr_ok_i(addr_ok),
    .data_sram_data_ok_i(data_ok),
    .data_sram_rdata_i (rdata),
    .ms_to_ws_valid_o  (ms_to_ws_valid),
    .ws_allowin_i      (ws_allowin),
    .ws_result_o       (ws_result),
    .ws_pc_o           (ws_pc),
    .ws_dest_o         (ws_dest),
    .ws_gr_we_o        (ws_gr_we),
    .ms_excp_o         (ms_excp),
    .ms_ale_o          (ms_ale),
    .ms_fwd_valid_o    (fwd_valid),
    .ms_fwd_ready_o    (fwd_ready),
    .ms_fwd_dest_o     (fwd_dest),
    .ms_fwd_data_o     (fwd_data)
  );

  typedef struct {
    logic [31:0] result;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        excp;
    logic        ale;
    int          lat;
    int          issue_cyc;
  } wb_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } rq_t;

  wb_t wb_q[$];
  rq_t rq_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  aok_dly = 0;
  int  dok_dly = 0;
  int  vec_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present one instruction, wait (bounded) for acceptance, queue expectations.
  task automatic issue(input logic [9:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic excp, input logic gr_we, input logic [4:0] dest,
                       input logic [31:0] pc, input bit exp_wb, input wb_t w,
                       input bit exp_rq, input rq_t r);
    int n;
    wb_t ww;
    es_to_ms_valid = 1'b1;
    es_mem_op = op; es_addr = addr; es_wdata = wd;
    es_excp = excp; es_gr_we = gr_we; es_dest = dest; es_pc = pc;
    #1;
    n = 0;
    while (!ms_allowin && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL issue_timeout actual=stalled required=accept pc=%h", pc);
    end
    if (exp_rq) rq_q.push_back(r);
    if (exp_wb) begin
      ww = w;
      ww.issue_cyc = cyc;
      wb_q.push_back(ww);
    end
    @(negedge clk);
    es_to_ms_valid = 1'b0;
  endtask

  // One directed vector with hand-computed bus and write-back expectations.
  task automatic vec(input logic [9:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic excp, input bit has_rq, input logic ewr,
                     input logic [1:0] esize, input logic [3:0] estrb,
                     input logic [31:0] ebwd, input logic [31:0] rd,
                     input logic [31:0] eres, input logic eale, input int lat);
    wb_t w;
    rq_t r;
    logic        gw;
    logic [4:0]  d;
    logic [31:0] pc;
    vec_n++;
    gw = !(op[5] | op[6] | op[7]);
    d  = 5'(vec_n);
    pc = 32'h1C000100 + 32'(vec_n * 4);
    w = '{result: eres, pc: pc, dest: d, gr_we: gw, excp: excp | eale, ale: eale,
          lat: lat, issue_cyc: 0};
    r = '{wr: ewr, size: esize, wstrb: estrb, addr: addr, wdata: ebwd, rdata: rd};
    issue(op, addr, wd, excp, gw, d, pc, 1'b1, w, has_rq, r);
  endtask

  // Bus slave: configurable addr_ok / data_ok delays, checks each request.
  initial begin : slave
    rq_t r;
    int ad, dd;
    logic [31:0] a0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && req) begin
        ad = aok_dly; dd = dok_dly; a0 = baddr;
        for (int k = 0; k < ad; k++) begin
          @(negedge clk);
          chk("req_held", 32'(req), 32'd1);
          chk("req_addr_stable", baddr, a0);
        end
        if (rq_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req actual=%h required=none", a0);
          r = '{wr: 1'b0, size: 2'd0, wstrb: 4'h0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0};
        end else begin
          r = rq_q.pop_front();
          chk("req_wr", 32'(wr), 32'(r.wr));
          chk("req_size", 32'(size), 32'(r.size));
          chk("req_wstrb", 32'(wstrb), 32'(r.wstrb));
          chk("req_addr", baddr, r.addr);
          chk("req_wdata", bwdata, r.wdata);
          $display("bus  req wr=%0d size=%0d wstrb=%h addr=%h wdata=%h", wr, size, wstrb, baddr, bwdata);
        end
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        repeat (dd) @(negedge clk);
        rdata = r.rdata; data_ok = 1'b1;
        @(negedge clk);
        data_ok = 1'b0; rdata = 32'h0;
      end
    end
  end

  // Write-back monitor: pops the scoreboard on every handover.
  always @(negedge clk) begin
    wb_t e;
    #1;
    if (!rst && ms_to_ws_valid && ws_allowin) begin
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wb actual=pc %h required=none", ws_pc);
      end else begin
        e = wb_q.pop_front();
        $display("wb   pc=%h result=%h dest=%0d gr_we=%0d excp=%0d ale=%0d", ws_pc, ws_result, ws_dest, ws_gr_we, ms_excp, ms_ale);
        chk("wb_result", ws_result, e.result);
        chk("wb_pc", ws_pc, e.pc);
        chk("wb_dest", 32'(ws_dest), 32'(e.dest));
        chk("wb_gr_we", 32'(ws_gr_we), 32'(e.gr_we));
        chk("wb_excp", 32'(ms_excp), 32'(e.excp));
        chk("wb_ale", 32'(ms_ale), 32'(e.ale));
        chk("fwd_valid", 32'(fwd_valid), 32'(e.gr_we));
        chk("fwd_ready", 32'(fwd_ready), 32'd1);
        chk("fwd_dest", 32'(fwd_dest), 32'(e.dest));
        chk("fwd_data", fwd_data, e.result);
        if (e.lat != 0) chk("wb_latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    wb_t w0;
    rq_t r0;
    int  n;
    rst = 1'b1; es_to_ms_valid = 1'b0; es_mem_op = OP_NONE; es_addr = 32'h0;
    es_wdata = 32'h0; es_gr_we = 1'b0; es_dest = 5'd0; es_pc = 32'h0;
    es_excp = 1'b0; flush = 1'b0; ws_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_size", 32'(size), 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_wdata", bwdata, 32'h0);
    chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_result", ws_result, 32'h0);
    chk("rst_excp", 32'(ms_excp), 32'd0);
    chk("rst_ale", 32'(ms_ale), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // op, addr, wdata, excp, has_rq, wr, size, wstrb, bus_wdata, rdata, result, ale, lat
    vec(OP_LD_B,  32'h1C000003, 32'h0,        0, 1, 0, 2'd0, 4'h0, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 0, 3);
    vec(OP_ST_H,  32'h1C000012, 32'h0000BEEF, 0, 1, 1, 2'd1, 4'hC, 32'hBEEFBEEF, 32'h0,        32'h1C000012, 0, 3);
    vec(OP_LD_W,  32'h1C000006, 32'h0,        0, 0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        32'h1C000006, 1, 1);
    vec(OP_LD_H,  32'h1C000052, 32'h0,        0, 1, 0, 2'd1, 4'h0, 32'h0,        32'h80017FFF, 32'hFFFF8001, 0, 3);
    vec(OP_LD_BU, 32'h1C000001, 32'h0,        0, 1, 0, 2'd0, 4'h0, 32'h0,        32'h00009A00, 32'h0000009A, 0, 3);
    vec(OP_LD_HU, 32'h1C000040, 32'h0,        0, 1, 0, 2'd1, 4'h0, 32'h0,        32'h1234F00D, 32'h0000F00D, 0, 3);
    vec(OP_ST_B,  32'h1C000003, 32'h12345677, 0, 1, 1, 2'd0, 4'h8, 32'h77777777, 32'h0,        32'h1C000003, 0, 3);
    vec(OP_ST_W,  32'h1C000008, 32'hCAFEF00D, 0, 1, 1, 2'd2, 4'hF, 32'hCAFEF00D, 32'h0,        32'h1C000008, 0, 3);
    vec(OP_RSVD,  32'h1C000001, 32'h0,        0, 0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        32'h1C000001, 0, 1);
    vec(OP_LD_W,  32'h1C000010, 32'h0,        1, 0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        32'h1C000010, 0, 1);
    vec(OP_NONE,  32'h00000042, 32'h0,        0, 0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        32'h00000042, 0, 1);
    vec(OP_ST_H,  32'h1C000001, 32'h00001111, 0, 0, 0, 2'd0, 4'h0, 32'h0,        32'h0,        32'h1C000001, 1, 1);
    aok_dly = 2; dok_dly = 1;
    vec(OP_LD_W,  32'h1C000014, 32'h0,        0, 1, 0, 2'd2, 4'h0, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 0, 6);
    repeat (8) @(negedge clk);
    aok_dly = 0; dok_dly = 0;

    // Flush while waiting for data: late data_ok must be swallowed.
    dok_dly = 2;
    w0 = '{result: 32'h0, pc: 32'h0, dest: 5'd0, gr_we: 1'b0, excp: 1'b0, ale: 1'b0, lat: 0, issue_cyc: 0};
    r0 = '{wr: 1'b0, size: 2'd2, wstrb: 4'h0, addr: 32'h1C000020, wdata: 32'h0, rdata: 32'hDEADBEEF};
    issue(OP_LD_W, 32'h1C000020, 32'h0, 1'b0, 1'b1, 5'd9, 32'h1C000200, 1'b0, w0, 1'b1, r0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fw_no_wb_valid", 32'(ms_to_ws_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fw_allowin_cxl1", 32'(ms_allowin), 32'd0);
    chk("fw_no_req", 32'(req), 32'd0);
    @(negedge clk); #1;
    chk("fw_allowin_cxl2", 32'(ms_allowin), 32'd0);
    @(negedge clk); #1;
    chk("fw_allowin_back", 32'(ms_allowin), 32'd1);
    dok_dly = 0;
    vec(OP_LD_W, 32'h1C000024, 32'h0, 0, 1, 0, 2'd2, 4'h0, 32'h0, 32'h12345678, 32'h12345678, 0, 3);
    repeat (4) @(negedge clk);

    // Flush in REQ with addr_ok stalled: request must persist until accepted.
    aok_dly = 3;
    r0 = '{wr: 1'b1, size: 2'd2, wstrb: 4'hF, addr: 32'h1C000030, wdata: 32'hA5A5A5A5, rdata: 32'h0};
    issue(OP_ST_W, 32'h1C000030, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0, 32'h1C000300, 1'b0, w0, 1'b1, r0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!ms_allowin && n < 20);
    chk("fr_cancel_cycles", 32'(n), 32'd4);
    aok_dly = 0;
    repeat (2) @(negedge clk);

    // Back-pressure in DONE, then handover plus new capture in one cycle.
    ws_allowin = 1'b0;
    vec(OP_NONE, 32'h11112222, 32'h0, 0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 32'h11112222, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_valid", 32'(ms_to_ws_valid), 32'd1);
      chk("bp_result", ws_result, 32'h11112222);
      chk("bp_allowin", 32'(ms_allowin), 32'd0);
      chk("bp_fwd_ready", 32'(fwd_ready), 32'd1);
      @(negedge clk);
    end
    ws_allowin = 1'b1;
    #1;
    chk("bp_release_allowin", 32'(ms_allowin), 32'd1);
    vec(OP_LD_HU, 32'h1C000042, 32'h0, 0, 1, 0, 2'd1, 4'h0, 32'h0, 32'hBEEF0000, 32'h0000BEEF, 0, 3);

    repeat (8) @(negedge clk);
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    chk("rq_queue_empty", 32'(rq_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
